// File: rtl/speech256_pkg.sv
// ---------------------------------------------------------------------------
// speech256_pkg
// Shared definitions for the Speech256 host-side allophone feeder.
//   ALLO_W      : width of an allophone code
//   S_*         : feeder FSM state encodings (2-bit, legacy-compatible)
//   PA1..PA5    : pause allophone codes, handy for stimulus
//   feeder_dbg_t: snapshot of the feeder FSM exposed on the debug port
// ---------------------------------------------------------------------------
package speech256_pkg;

  localparam int ALLO_W = 6;

  // Feeder FSM states
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_STROBE   = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_WAIT_RDY = 2'd3;

  // Pause allophones
  localparam logic [ALLO_W-1:0] PA1 = 6'd0;
  localparam logic [ALLO_W-1:0] PA2 = 6'd1;
  localparam logic [ALLO_W-1:0] PA3 = 6'd2;
  localparam logic [ALLO_W-1:0] PA4 = 6'd3;
  localparam logic [ALLO_W-1:0] PA5 = 6'd4;

  // Debug view of the feeder FSM
  typedef struct packed {
    logic [1:0] state;    // current S_* state
    logic [7:0] ack_cnt;  // cycles spent in S_WAIT_ACK with ldq still high
  } feeder_dbg_t;

endpackage

// File: rtl/allo_fifo.sv
// ---------------------------------------------------------------------------
// allo_fifo
// Single-clock FIFO holding allophone codes, with a registered entry count.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write din (ignored while full)
//   pop    in   advance the head (ignored while empty)
//   flush  in   discard all entries; wins over push/pop in the same cycle
//   din    in   code to write
//   dout   out  code at the head (valid while empty=0)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   level  out  current entry count
// ---------------------------------------------------------------------------
module allo_fifo
  import speech256_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ALLO_W-1:0] din,
  output logic [ALLO_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0]   C_FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

  logic [ALLO_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // Requests are qualified here so the caller never corrupts the pointers.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == C_FULL_CNT);
  assign empty = (r_count == '0);
  assign level = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are ADDR_W wide and DEPTH is a power of two, so the natural
  // overflow of the adder is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/allo_feeder.sv
// ---------------------------------------------------------------------------
// allo_feeder
// Buffers allophone codes from the host and hands them one at a time to the
// Speech256 controller's load interface.
//
// Handshake with the controller: ldq=1 means the controller can take a code.
// When ldq=1 and the FIFO is non-empty in cycle n, the head is popped and
// presented on data_out with data_stb=1 for exactly cycle n+1. The controller
// is expected to drop ldq as acknowledgement; the feeder then waits for ldq to
// rise again before it may strobe the next code. If ldq never falls within
// ACK_TIMEOUT cycles of waiting, ack_err pulses and the code is abandoned.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, clears all state
//   wr_data   in   allophone code from the host
//   wr_en     in   write request, one code per cycle
//   flush     in   discard all queued codes (an in-flight strobe completes)
//   ldq       in   controller load request
//   data_out  out  code to the controller, held until the next strobe
//   data_stb  out  one-cycle strobe qualifying data_out
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   level     out  FIFO entry count
//   busy      out  FIFO non-empty or FSM not idle
//   overflow  out  one-cycle pulse: a write was dropped because FIFO was full
//   ack_err   out  one-cycle pulse: ldq did not fall after a strobe
//   dbg       out  FSM state and acknowledge counter
// ---------------------------------------------------------------------------
module allo_feeder
  import speech256_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ALLO_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              flush,
  input  logic              ldq,
  output logic [ALLO_W-1:0] data_out,
  output logic              data_stb,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow,
  output logic              ack_err,
  output feeder_dbg_t       dbg
);

  // The counter value seen in the last S_WAIT_ACK cycle before giving up.
  // The counter is cleared on the strobe cycle, so ack_err lands
  // ACK_TIMEOUT+1 cycles after data_stb.
  localparam logic [7:0] C_ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] C_CNT_ONE  = 8'd1;

  // Registered state
  logic [1:0]        r_state;
  logic [7:0]        r_ack_cnt;
  logic [ALLO_W-1:0] r_data_out;
  logic              r_data_stb;
  logic              r_overflow;
  logic              r_ack_err;

  // FIFO interface
  logic              w_push;
  logic              w_pop;
  logic [ALLO_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W:0]   w_level;

  // Next-state values
  logic [1:0]        w_state_nxt;
  logic [7:0]        w_ack_cnt_nxt;
  logic [ALLO_W-1:0] w_data_out_nxt;
  logic              w_data_stb_nxt;
  logic              w_ack_err_nxt;
  logic              w_overflow_nxt;

  // flush drops a same-cycle write silently; the FIFO itself drops writes
  // while full.
  assign w_push = wr_en & ~flush;

  // Pop only from idle with the controller ready. This is also what keeps a
  // strobe from ever being issued while ldq is low.
  assign w_pop = (r_state == S_IDLE) & ldq & ~w_empty;

  // A drop is reported whenever the FIFO was full at the write, even if a pop
  // frees a slot in that same cycle.
  assign w_overflow_nxt = wr_en & w_full & ~flush;

  allo_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .din   (wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ack_cnt_nxt  = r_ack_cnt;
    w_data_out_nxt = r_data_out;
    w_data_stb_nxt = 1'b0;
    w_ack_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_data_out_nxt = w_head;
          w_data_stb_nxt = 1'b1;
          w_state_nxt    = S_STROBE;
        end
      end
      S_STROBE: begin
        w_ack_cnt_nxt = '0;
        w_state_nxt   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!ldq) begin
          w_state_nxt = S_WAIT_RDY;
        end else if (r_ack_cnt == C_ACK_LAST) begin
          // Code is considered lost; it is not re-sent.
          w_ack_err_nxt = 1'b1;
          w_ack_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + C_CNT_ONE;
        end
      end
      S_WAIT_RDY: begin
        // No timeout: the controller may be speaking for a long time.
        if (ldq) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ack_cnt  <= '0;
      r_data_out <= '0;
      r_data_stb <= 1'b0;
      r_overflow <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack_cnt  <= w_ack_cnt_nxt;
      r_data_out <= w_data_out_nxt;
      r_data_stb <= w_data_stb_nxt;
      r_overflow <= w_overflow_nxt;
      r_ack_err  <= w_ack_err_nxt;
    end
  end

  // Status flags are decoded only from registers, never from inputs.
  assign data_out    = r_data_out;
  assign data_stb    = r_data_stb;
  assign overflow    = r_overflow;
  assign ack_err     = r_ack_err;
  assign full        = w_full;
  assign empty       = w_empty;
  assign level       = w_level;
  assign busy        = ~w_empty | (r_state != S_IDLE);
  assign dbg.state   = r_state;
  assign dbg.ack_cnt = r_ack_cnt;

endmodule

// File: tb/tb_allo_feeder.sv
// ---------------------------------------------------------------------------
// tb_allo_feeder
// Self-checking bench for allo_feeder. Every strobe is compared against a
// queue of codes the bench expects the FIFO to have accepted.
// ---------------------------------------------------------------------------
module tb_allo_feeder;
  import speech256_pkg::*;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 15;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic [ALLO_W-1:0] wr_data;
  logic              wr_en;
  logic              flush;
  logic              ldq;
  logic [ALLO_W-1:0] data_out;
  logic              data_stb;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              overflow;
  logic              ack_err;
  feeder_dbg_t       dbg;

  allo_feeder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .ldq      (ldq),
    .data_out (data_out),
    .data_stb (data_stb),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .ack_err  (ack_err),
    .dbg      (dbg)
  );

  // Scoreboard
  logic [ALLO_W-1:0] exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   stb_count = 0;
  logic prev_stb  = 1'b0;

  // Advance one cycle and sample 1 time unit after the edge. Any strobe seen
  // is checked against the scoreboard, against ldq as it was sampled at the
  // edge, and against the previous cycle's strobe.
  task automatic step();
    logic              ldq_before;
    logic [ALLO_W-1:0] exp_d;
    ldq_before = ldq;
    @(posedge clk);
    #1;
    if (data_stb === 1'b1) begin
      stb_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stb_unexpected: data_out=%h but no code expected", data_out);
      end else begin
        exp_d = exp_q.pop_front();
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL stb_data: data_out=%h expected %h", data_out, exp_d);
        end
      end
      checks++;
      if (ldq_before !== 1'b1) begin
        errors++;
        $display("FAIL stb_without_ldq: ldq at edge=%b expected 1", ldq_before);
      end
      checks++;
      if (prev_stb === 1'b1) begin
        errors++;
        $display("FAIL stb_consecutive: data_stb=1 on two cycles, expected a gap");
      end
    end
    prev_stb = data_stb;
  endtask

  // One write cycle; the code is expected on the output if the bench's own
  // queue says the FIFO has room and nothing discards it.
  task automatic do_write(input logic [ALLO_W-1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    if (!flush && !rst && exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_stb(input int max_cycles, input string name);
    int n;
    n = 0;
    while (data_stb !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (data_stb !== 1'b1) begin
      errors++;
      $display("FAIL %s: data_stb=%b after %0d cycles, expected 1", name, data_stb, n);
    end
  endtask

  task automatic check_reset_values(input string name);
    logic [18:0] got;
    logic [18:0] want;
    got  = {data_out, data_stb, full, empty, level, busy, overflow, ack_err, dbg.state};
    want = {6'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_IDLE};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: {data_out,stb,full,empty,level,busy,ovf,ack_err,state}=%h expected %h",
               name, got, want);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;
    ldq     = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_values("reset_values");
    step();
    check_reset_values("reset_values_hold");
  endtask

  task automatic test_basic();
    int s0;
    s0  = stb_count;
    ldq = 1'b1;
    do_write(6'h2A);
    checks++;
    if (empty !== 1'b0 || data_stb !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty_fall: empty=%b stb=%b expected 0 0", empty, data_stb);
    end
    step();
    checks++;
    if (data_stb !== 1'b1 || data_out !== 6'h2A) begin
      errors++;
      $display("FAIL basic_strobe: stb=%b data_out=%h expected 1 2a", data_stb, data_out);
    end
    ldq = 1'b0;
    step();
    checks++;
    if (dbg.state !== S_WAIT_ACK || data_stb !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_ack: state=%0d stb=%b expected %0d 0", dbg.state, data_stb, S_WAIT_ACK);
    end
    step();
    checks++;
    if (dbg.state !== S_WAIT_RDY) begin
      errors++;
      $display("FAIL basic_wait_rdy: state=%0d expected %0d", dbg.state, S_WAIT_RDY);
    end
    repeat (3) step();
    checks++;
    if (data_out !== 6'h2A) begin
      errors++;
      $display("FAIL basic_data_hold: data_out=%h expected 2a", data_out);
    end
    ldq = 1'b1;
    step();
    checks++;
    if (dbg.state !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: state=%0d busy=%b expected %0d 0", dbg.state, busy, S_IDLE);
    end
    checks++;
    if (stb_count - s0 != 1) begin
      errors++;
      $display("FAIL basic_stb_count: strobes=%0d expected 1", stb_count - s0);
    end
  endtask

  task automatic test_order();
    int s0;
    ldq = 1'b0;
    step();
    s0 = stb_count;
    do_write(6'h01);
    do_write(6'h05);
    do_write(6'h3F);
    repeat (10) step();
    checks++;
    if (stb_count != s0 || level !== 5'd3) begin
      errors++;
      $display("FAIL order_backpressure: strobes=%0d level=%0d expected 0 3", stb_count - s0, level);
    end
    ldq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_stb(20, "order_strobe");
      ldq = 1'b0;
      repeat (50) step();
      ldq = 1'b1;
    end
    step();
    checks++;
    if (stb_count - s0 != 3 || empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL order_done: strobes=%0d empty=%b pending=%0d expected 3 1 0",
               stb_count - s0, empty, exp_q.size());
    end
  endtask

  task automatic test_full();
    logic [ALLO_W-1:0] d;
    ldq = 1'b0;
    step();
    step();
    for (int i = 0; i < DEPTH; i++) begin
      d = 6'($urandom_range(0, 63));
      do_write(d);
    end
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_after_16: full=%b level=%0d ovf=%b expected 1 16 0", full, level, overflow);
    end
    do_write(6'h11);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL full_overflow: ovf=%b level=%0d expected 1 16", overflow, level);
    end
    step();
    checks++;
    if (overflow !== 1'b0 || level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_overflow_pulse: ovf=%b level=%0d full=%b expected 0 16 1", overflow, level, full);
    end
  endtask

  // FIFO is full on entry; the write lands in the same cycle as the pop.
  task automatic test_push_pop_full();
    ldq = 1'b1;
    do_write(6'h22);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd15 || data_stb !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_full: ovf=%b level=%0d stb=%b expected 1 15 1", overflow, level, data_stb);
    end
  endtask

  // ldq stays high, so every strobe times out; entered on a strobe cycle.
  task automatic test_timeout();
    int n;
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (ack_err !== 1'b1 && n < 40);
      checks++;
      if (n != ACK_TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_latency: ack_err after %0d cycles expected %0d", n, ACK_TIMEOUT + 1);
      end
      step();
      checks++;
      if (data_stb !== 1'b1 || ack_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_next_strobe: stb=%b ack_err=%b expected 1 0", data_stb, ack_err);
      end
    end
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drain: pending=%0d busy=%b expected 0 0", exp_q.size(), busy);
    end
    ldq = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int s0;
    ldq = 1'b0;
    step();
    do_write(PA1);
    do_write(PA3);
    do_write(PA5);
    do_write(6'h15);
    do_write(6'h2B);
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL flush_fill: level=%0d expected 5", level);
    end
    flush = 1'b1;
    do_write(6'h3C);
    flush = 1'b0;
    exp_q.delete();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: level=%0d empty=%b ovf=%b expected 0 1 0", level, empty, overflow);
    end
    s0  = stb_count;
    ldq = 1'b1;
    repeat (5) step();
    checks++;
    if (stb_count != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_strobe: strobes=%0d busy=%b expected 0 0", stb_count - s0, busy);
    end
    ldq = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int s0;
    do_write(6'h07);
    do_write(6'h08);
    do_write(6'h09);
    ldq = 1'b1;
    step();
    checks++;
    if (data_stb !== 1'b1 || dbg.state !== S_STROBE) begin
      errors++;
      $display("FAIL rstmid_strobe: stb=%b state=%0d expected 1 %0d", data_stb, dbg.state, S_STROBE);
    end
    step();
    rst = 1'b1;
    step();
    check_reset_values("rstmid_values");
    rst = 1'b0;
    exp_q.delete();
    s0 = stb_count;
    repeat (4) step();
    checks++;
    if (stb_count != s0 || level !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_lost: strobes=%0d level=%0d expected 0 0", stb_count - s0, level);
    end
    ldq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_push_pop_full();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the tests completed");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/allo_feeder.md
Name: allo_feeder

Overview:
Host-side transmitter for the Speech256 controller's allophone load interface. It buffers 6-bit allophone codes written by the host or a test sequencer in a small FIFO. It presents each code to the controller with a one-cycle data_stb, but only when the controller's ldq indicates it can accept one. It sits between the host bus / SPI front end and the controller, and gives the host flow-control and status flags.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH).
ACK_TIMEOUT, 15, cycles to wait for ldq to fall after a strobe before declaring ack_err; range 1..255.

Ports:
clk  in  1  global Speech256 clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high; clears all state
wr_data  in  6  allophone code from host
wr_en  in  1  write request; one code per cycle
flush  in  1  discard all queued codes
ldq  in  1  controller load request; high when the controller can take an allophone
data_out  out  6  allophone code to the controller data_in
data_stb  out  1  one-cycle strobe qualifying data_out
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  ADDR_W+1  current entry count
busy  out  1  high when FIFO is non-empty or the FSM is not in S_IDLE
overflow  out  1  one-cycle pulse: a write was dropped because the FIFO was full
ack_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset values: data_out=0, data_stb=0, full=0, empty=1, level=0, busy=0, overflow=0, ack_err=0; FSM in S_IDLE; FIFO pointers 0; timeout counter 0.
- All outputs are registered. full, empty and level reflect the registered count.

FIFO:
- Write accepted when wr_en=1, full=0, flush=0.
- wr_en=1 while full=1 → write dropped, overflow=1 next cycle. This holds even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop → level unchanged, data order preserved.
- Pointers wrap modulo DEPTH.
- flush=1 → next cycle level=0, empty=1. A same-cycle wr_en is dropped without overflow.
- flush does not abort a strobe already in progress.

FSM states:
- S_IDLE: if ldq=1 and empty=0 → pop head, go to S_STROBE.
- S_STROBE (1 cycle): data_stb=1, data_out=popped code; go to S_WAIT_ACK; clear timeout counter.
- S_WAIT_ACK: if ldq=0 → S_WAIT_RDY. Otherwise increment the counter; when counter reaches ACK_TIMEOUT → ack_err=1 for one cycle, go to S_IDLE. The code is treated as lost and is not re-sent.
- S_WAIT_RDY: wait for ldq=1 → S_IDLE. No timeout, since the controller may speak for a long time.

Timing and handshake rules:
- Latency: ldq=1 and non-empty sampled in cycle n → data_stb=1 in cycle n+1.
- The controller drops ldq in cycle n+2. The minimum period between strobes is 4 cycles.
- data_out holds its value after the strobe until the next strobe.
- data_stb is never high on two consecutive cycles.
- A strobe is never issued while ldq=0.
- ldq=1 with empty=1 → stay in S_IDLE; a write arriving later starts a strobe the cycle after it is visible in the FIFO.
- rst asserted mid-operation → the next cycle has data_stb=0, FIFO empty, FSM in S_IDLE. Queued codes are lost.

Decomposition:
- Shared package speech256_pkg:
  - ALLO_W=6
  - state encoding constants S_IDLE=2'd0, S_STROBE=2'd1, S_WAIT_ACK=2'd2, S_WAIT_RDY=2'd3
  - allophone code constants for pauses PA1..PA5 (0..4), for benches
- One sub-module, allo_fifo:
  - synchronous single-clock FIFO, parameters DEPTH/ADDR_W, registered count
  - ports: push, pop, flush, din, dout, full, empty, level
- allo_feeder instantiates allo_fifo plus the FSM and timeout counter.

Test Plan:
1. Basic handshake: after reset, write 0x2A with ldq=1 held → data_stb pulses exactly once, data_out=0x2A, 2 cycles after the write, i.e. 1 cycle after empty falls. Model ldq falling 1 cycle after the strobe; FSM returns to S_IDLE when ldq rises again; busy=0 afterwards.
2. Ordering/back-pressure: write 0x01, 0x05, 0x3F with ldq=0; raise ldq 10 cycles later and model a 50-cycle controller speaking time per code → three strobes in order 0x01, 0x05, 0x3F, each only after ldq re-rises; empty=1 at the end.
3. Full/overflow: write 17 codes back-to-back with ldq=0, DEPTH=16 → full=1 and level=16 after 16 writes; 17th write gives overflow=1 for one cycle; level stays 16.
4. Simultaneous push/pop at full: full FIFO, ldq=1, wr_en=1 in the pop cycle → write dropped, overflow=1, level=15 afterwards.
5. Ack timeout: strobe issued while ldq stuck at 1 → ack_err pulses ACK_TIMEOUT+1 cycles after data_stb, i.e. 16 cycles; the next queued code is strobed afterwards.
6. Flush and reset: queue 5 codes, assert flush together with wr_en → level=0 next cycle, overflow=0, no strobe. Then queue 3 codes, start a strobe, assert rst in the S_STROBE+1 cycle → all outputs at reset values next cycle.
